// File: rtl/serv_mem_responder_if.sv
// Instruction and data bus bundle between a SERV-style core and the memory responder.
// Signal names follow the core-side convention: i_/o_ are as seen by the responder.
interface serv_mem_responder_if;
  logic        i_ibus_cyc;
  logic [31:0] i_ibus_adr;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic        i_dbus_cyc;
  logic [31:0] i_dbus_adr;
  logic        i_dbus_we;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;

  modport master (
    output i_ibus_cyc, i_ibus_adr, i_dbus_cyc, i_dbus_adr, i_dbus_we, i_dbus_dat, i_dbus_sel,
    input  o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack
  );

  modport slave (
    input  i_ibus_cyc, i_ibus_adr, i_dbus_cyc, i_dbus_adr, i_dbus_we, i_dbus_dat, i_dbus_sel,
    output o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack
  );
endinterface

// File: rtl/serv_mem_responder.sv
// Arbitrates the ibus and dbus of a SERV-style core onto one synchronous single-port RAM.
// dbus has priority; out-of-range accesses complete normally but read zero and set a sticky error.
module serv_mem_responder #(
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  serv_mem_responder_if.slave bus,
  output logic          o_ram_en,
  output logic [AW-1:0] o_ram_a,
  output logic [3:0]    o_ram_we,
  output logic [31:0]   o_ram_di,
  input  logic [31:0]   i_ram_do,
  output logic          o_err
);

  typedef enum logic [1:0] {StIdle, StRdWait, StRdCap, StWrAck} state_e;

  state_e      state_q;
  logic        gnt_dbus_q;
  logic        oor_q;
  logic [31:0] rdata_q;
  logic        ibus_ack_q;
  logic        dbus_ack_q;
  logic        err_q;

  logic        sel_dbus;
  logic        req;
  logic [31:0] adr;
  logic        oor;
  logic        wr;
  logic        grant;
  logic        unused_adr;

  always_comb begin
    sel_dbus = bus.i_dbus_cyc;
    req      = bus.i_dbus_cyc | bus.i_ibus_cyc;
    adr      = sel_dbus ? bus.i_dbus_adr : bus.i_ibus_adr;
    oor      = |adr[31:AW+2];
    wr       = sel_dbus & bus.i_dbus_we;
    // Grants are decided combinationally so the RAM sees the address in the request cycle.
    grant    = rst_n && (state_q == StIdle) && req;
    o_ram_en = grant & ~oor;
    o_ram_a  = adr[AW+1:2];
    o_ram_we = (grant && !oor && wr) ? bus.i_dbus_sel : 4'b0000;
    o_ram_di = bus.i_dbus_dat;
  end

  assign unused_adr = ^adr[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_dbus_q <= 1'b0;
      oor_q      <= 1'b0;
      rdata_q    <= 32'h0;
      ibus_ack_q <= 1'b0;
      dbus_ack_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ibus_ack_q <= 1'b0;
      dbus_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            gnt_dbus_q <= sel_dbus;
            oor_q      <= oor;
            if (oor) err_q <= 1'b1;
            if (wr) begin
              dbus_ack_q <= 1'b1;
              state_q    <= StWrAck;
            end else begin
              state_q    <= StRdWait;
            end
          end
        end
        StRdWait: begin
          rdata_q    <= oor_q ? 32'h0 : i_ram_do;
          ibus_ack_q <= ~gnt_dbus_q;
          dbus_ack_q <= gnt_dbus_q;
          state_q    <= StRdCap;
        end
        StRdCap: state_q <= StIdle;
        StWrAck: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_ibus_rdt = rdata_q;
  assign bus.o_dbus_rdt = rdata_q;
  assign bus.o_ibus_ack = ibus_ack_q;
  assign bus.o_dbus_ack = dbus_ack_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_serv_mem_responder.sv
// Directed bench for serv_mem_responder with a behavioural synchronous RAM (AW=5).
module tb_serv_mem_responder;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ram_en;
  logic [AW-1:0] ram_a;
  logic [3:0]    ram_we;
  logic [31:0]   ram_di;
  logic [31:0]   ram_do = 32'h0;
  logic          err;
  logic [31:0]   mem [2**AW];

  int total = 0;
  int bad   = 0;

  serv_mem_responder_if bus ();

  serv_mem_responder #(.AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .o_ram_en (ram_en),
    .o_ram_a  (ram_a),
    .o_ram_we (ram_we),
    .o_ram_di (ram_di),
    .i_ram_do (ram_do),
    .o_err    (err)
  );

  always #5 clk = ~clk;

  // Read-first synchronous RAM with byte enables.
  always_ff @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
      end
      ram_do <= mem[ram_a];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus.i_dbus_cyc = 1'b1;
    bus.i_dbus_we  = 1'b1;
    bus.i_dbus_adr = adr;
    bus.i_dbus_dat = dat;
    bus.i_dbus_sel = sel;
    #1;
    chk("wr_grant_we", {28'h0, ram_we}, {28'h0, sel});
    chk("wr_grant_ack", {31'h0, bus.o_dbus_ack}, 32'h0);
    step();
    chk("wr_ack", {31'h0, bus.o_dbus_ack}, 32'h1);
    bus.i_dbus_cyc = 1'b0;
    bus.i_dbus_we  = 1'b0;
    step();
    chk("wr_single_ack", {31'h0, bus.o_dbus_ack}, 32'h0);
  endtask

  task automatic do_dread(input logic [31:0] adr, input logic [31:0] exp, input logic exp_en);
    bus.i_dbus_cyc = 1'b1;
    bus.i_dbus_we  = 1'b0;
    bus.i_dbus_adr = adr;
    #1;
    chk("rd_grant_en", {31'h0, ram_en}, {31'h0, exp_en});
    step();
    chk("rd_wait_ack", {31'h0, bus.o_dbus_ack}, 32'h0);
    step();
    chk("rd_ack", {31'h0, bus.o_dbus_ack}, 32'h1);
    chk("rd_data", bus.o_dbus_rdt, exp);
    bus.i_dbus_cyc = 1'b0;
    step();
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.i_ibus_cyc = 1'b1;
    bus.i_ibus_adr = 32'h8;
    bus.i_dbus_cyc = 1'b0;
    bus.i_dbus_adr = 32'h0;
    bus.i_dbus_we  = 1'b0;
    bus.i_dbus_dat = 32'h0;
    bus.i_dbus_sel = 4'h0;
    step();
    step();
    // Reset state, with a request held during reset that must not be granted.
    chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
    chk("rst_ram_we", {28'h0, ram_we}, 32'h0);
    chk("rst_iack", {31'h0, bus.o_ibus_ack}, 32'h0);
    chk("rst_dack", {31'h0, bus.o_dbus_ack}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_rdata", bus.o_ibus_rdt, 32'h0);
    bus.i_ibus_cyc = 1'b0;
    rst_n          = 1'b1;
    step();
    chk("idle_ram_en", {31'h0, ram_en}, 32'h0);

    // Full-word write then ibus fetch of the same word.
    bus.i_dbus_cyc = 1'b1;
    bus.i_dbus_we  = 1'b1;
    bus.i_dbus_adr = 32'h8;
    bus.i_dbus_dat = 32'hDEADBEEF;
    bus.i_dbus_sel = 4'hF;
    #1;
    chk("w1_en", {31'h0, ram_en}, 32'h1);
    chk("w1_we", {28'h0, ram_we}, 32'hF);
    chk("w1_a", {27'h0, ram_a}, 32'h2);
    chk("w1_di", ram_di, 32'hDEADBEEF);
    chk("w1_ack_early", {31'h0, bus.o_dbus_ack}, 32'h0);
    step();
    chk("w1_ack", {31'h0, bus.o_dbus_ack}, 32'h1);
    chk("w1_ack_en", {31'h0, ram_en}, 32'h0);
    bus.i_dbus_cyc = 1'b0;
    bus.i_dbus_we  = 1'b0;
    step();
    bus.i_ibus_cyc = 1'b1;
    bus.i_ibus_adr = 32'h8;
    #1;
    chk("f1_en", {31'h0, ram_en}, 32'h1);
    chk("f1_we", {28'h0, ram_we}, 32'h0);
    chk("f1_a", {27'h0, ram_a}, 32'h2);
    step();
    chk("f1_wait_ack", {31'h0, bus.o_ibus_ack}, 32'h0);
    chk("f1_wait_en", {31'h0, ram_en}, 32'h0);
    step();
    chk("f1_ack", {31'h0, bus.o_ibus_ack}, 32'h1);
    chk("f1_dack", {31'h0, bus.o_dbus_ack}, 32'h0);
    chk("f1_rdt", bus.o_ibus_rdt, 32'hDEADBEEF);
    chk("f1_drdt", bus.o_dbus_rdt, 32'hDEADBEEF);
    bus.i_ibus_cyc = 1'b0;
    step();

    // Byte-lane write merge; writes leave the read-data register alone.
    do_write(32'h0C, 32'h11223344, 4'hF);
    do_write(32'h0C, 32'h0000AB00, 4'b0010);
    chk("rdata_hold", bus.o_dbus_rdt, 32'hDEADBEEF);
    do_dread(32'h0C, 32'h1122AB44, 1'b1);

    // Empty byte mask still acks and changes nothing.
    do_write(32'h0C, 32'hFFFFFFFF, 4'h0);
    do_dread(32'h0C, 32'h1122AB44, 1'b1);

    // Simultaneous requests: dbus first, ibus served after.
    bus.i_ibus_cyc = 1'b1;
    bus.i_ibus_adr = 32'h8;
    bus.i_dbus_cyc = 1'b1;
    bus.i_dbus_adr = 32'h0C;
    #1;
    chk("both_a", {27'h0, ram_a}, 32'h3);
    step();
    chk("both_wait_en", {31'h0, ram_en}, 32'h0);
    step();
    chk("both_dack", {31'h0, bus.o_dbus_ack}, 32'h1);
    chk("both_iack0", {31'h0, bus.o_ibus_ack}, 32'h0);
    chk("both_drdt", bus.o_dbus_rdt, 32'h1122AB44);
    bus.i_dbus_cyc = 1'b0;
    step();
    chk("both_ib_en", {31'h0, ram_en}, 32'h1);
    chk("both_ib_a", {27'h0, ram_a}, 32'h2);
    step();
    chk("both_ib_wait", {31'h0, bus.o_ibus_ack}, 32'h0);
    step();
    chk("both_iack", {31'h0, bus.o_ibus_ack}, 32'h1);
    chk("both_irdt", bus.o_ibus_rdt, 32'hDEADBEEF);
    bus.i_ibus_cyc = 1'b0;
    step();
    chk("both_iack_once", {31'h0, bus.o_ibus_ack}, 32'h0);
    chk("both_idle_en", {31'h0, ram_en}, 32'h0);

    // Request withdrawn after grant still completes.
    bus.i_dbus_cyc = 1'b1;
    bus.i_dbus_adr = 32'h8;
    step();
    bus.i_dbus_cyc = 1'b0;
    step();
    chk("wd_ack", {31'h0, bus.o_dbus_ack}, 32'h1);
    chk("wd_rdt", bus.o_dbus_rdt, 32'hDEADBEEF);
    step();

    // Out-of-range read: no RAM access, zero data, sticky error.
    bus.i_dbus_cyc = 1'b1;
    bus.i_dbus_adr = 32'h100;
    #1;
    chk("oor_en", {31'h0, ram_en}, 32'h0);
    chk("oor_we", {28'h0, ram_we}, 32'h0);
    step();
    chk("oor_err", {31'h0, err}, 32'h1);
    step();
    chk("oor_ack", {31'h0, bus.o_dbus_ack}, 32'h1);
    chk("oor_rdt", bus.o_dbus_rdt, 32'h0);
    bus.i_dbus_cyc = 1'b0;
    step();
    bus.i_ibus_cyc = 1'b1;
    bus.i_ibus_adr = 32'h8;
    step();
    step();
    chk("oor_f_ack", {31'h0, bus.o_ibus_ack}, 32'h1);
    chk("oor_f_rdt", bus.o_ibus_rdt, 32'hDEADBEEF);
    chk("oor_err_sticky", {31'h0, err}, 32'h1);
    bus.i_ibus_cyc = 1'b0;
    step();

    // Reset in RD_WAIT drops the ack; held fetch is re-served after release.
    bus.i_ibus_cyc = 1'b1;
    bus.i_ibus_adr = 32'h0C;
    #1;
    chk("rr_grant_en", {31'h0, ram_en}, 32'h1);
    step();
    rst_n = 1'b0;
    step();
    chk("rr_iack", {31'h0, bus.o_ibus_ack}, 32'h0);
    chk("rr_err", {31'h0, err}, 32'h0);
    chk("rr_rdata", bus.o_ibus_rdt, 32'h0);
    chk("rr_en", {31'h0, ram_en}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rr_regrant_en", {31'h0, ram_en}, 32'h1);
    chk("rr_regrant_a", {27'h0, ram_a}, 32'h3);
    step();
    chk("rr_wait_ack", {31'h0, bus.o_ibus_ack}, 32'h0);
    step();
    chk("rr_ack", {31'h0, bus.o_ibus_ack}, 32'h1);
    chk("rr_rdt", bus.o_ibus_rdt, 32'h1122AB44);
    bus.i_ibus_cyc = 1'b0;
    step();
    chk("rr_ack_once", {31'h0, bus.o_ibus_ack}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
